sa3x3_ctrl: RTL

SA3X3_CTRL -- requirements
Module: sa3x3_ctrl

---
 rtl/sa3x3_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sa3x3_ctrl.sv
// sa3x3_ctrl: job sequencer for a 3x3 weight-stationary systolic array.
// It clears the array, shifts in weights bottom row first, skews the activation
// vectors into the rows and deskews the column partial sums into result vectors.
// Optional build macro SA_CTRL_RELU_EN clamps negative (bit 7 set) result bytes to 0.
module sa3x3_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LAT   = 6    // accept-to-result latency; the array timing only supports 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [71:0]      weights,
    input  logic             act_valid,
    output logic             act_ready,
    input  logic [23:0]      act_vec,
    output logic             busy,
    output logic             done,
    output logic             sa_clear,
    output logic             sa_weight_load,
    output logic [7:0]       sa_w1,
    output logic [7:0]       sa_w2,
    output logic [7:0]       sa_w3,
    output logic [7:0]       sa_act1,
    output logic [7:0]       sa_act2,
    output logic [7:0]       sa_act3,
    output logic [7:0]       sa_psum1,
    output logic [7:0]       sa_psum2,
    output logic [7:0]       sa_psum3,
    input  logic [7:0]       sa_pout1,
    input  logic [7:0]       sa_pout2,
    input  logic [7:0]       sa_pout3,
    output logic             res_valid,
    output logic [23:0]      res_vec
);

    localparam int unsigned B_W = 8;
    localparam int unsigned V_W = 3 * B_W;
    localparam int unsigned K_W = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOADW, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3*V_W-1:0] wgt_q, wgt_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             accept;
    logic [V_W-1:0]   wrow;

    logic [B_W-1:0]   act1_q, act2_s_q, act2_q, act3_s0_q, act3_s1_q, act3_q;
    logic [LAT-1:0]   vld_q;
    logic [B_W-1:0]   p1_s0_q, p1_s1_q, p2_s0_q;

    function automatic logic [B_W-1:0] relu(input logic [B_W-1:0] b);
`ifdef SA_CTRL_RELU_EN
        relu = b[B_W-1] ? '0 : b;
`else
        relu = b;
`endif
    endfunction

    assign accept = act_valid & act_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_CLR;
            S_CLR:    state_d = S_LOADW;
            S_LOADW:  if (k_q == K_W'(2)) state_d = (num_q == '0) ? S_DONE : S_STREAM;
            S_STREAM: if (accept && (CNT_W'(cnt_q + CNT_W'(1)) == num_q)) state_d = S_DRAIN;
            S_DRAIN:  if (vld_q[LAT-2:0] == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        sa_clear       = 1'b0;
        sa_weight_load = 1'b0;
        act_ready      = 1'b0;
        wrow           = '0;
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        sa_clear       = (state_q == S_CLR);
        sa_weight_load = (state_q == S_LOADW);
        act_ready      = (state_q == S_STREAM) && (cnt_q < num_q);
        if (state_q == S_LOADW) begin
            case (k_q)
                K_W'(0): wrow = wgt_q[2*V_W +: V_W];
                K_W'(1): wrow = wgt_q[V_W +: V_W];
                K_W'(2): wrow = wgt_q[0 +: V_W];
                default: wrow = '0;
            endcase
        end
    end

    // Job parameter capture, accept counter and weight-load cycle counter
    always_comb begin
        num_d = num_q;
        wgt_d = wgt_q;
        cnt_d = cnt_q;
        k_d   = (state_q == S_LOADW) ? K_W'(k_q + K_W'(1)) : '0;
        if ((state_q == S_IDLE) && start) begin
            num_d = num_vec;
            wgt_d = weights;
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_q <= '0;
            wgt_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
        end else begin
            num_q <= num_d;
            wgt_q <= wgt_d;
            cnt_q <= cnt_d;
            k_q   <= k_d;
        end
    end

    // Input skew, valid pipeline and output deskew; empty slots carry zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act1_q    <= '0;
            act2_s_q  <= '0;
            act2_q    <= '0;
            act3_s0_q <= '0;
            act3_s1_q <= '0;
            act3_q    <= '0;
            vld_q     <= '0;
            p1_s0_q   <= '0;
            p1_s1_q   <= '0;
            p2_s0_q   <= '0;
        end else begin
            act1_q    <= accept ? act_vec[0 +: B_W]     : '0;
            act2_s_q  <= accept ? act_vec[B_W +: B_W]   : '0;
            act2_q    <= act2_s_q;
            act3_s0_q <= accept ? act_vec[2*B_W +: B_W] : '0;
            act3_s1_q <= act3_s0_q;
            act3_q    <= act3_s1_q;
            vld_q     <= {vld_q[LAT-2:0], accept};
            p1_s0_q   <= sa_pout1;
            p1_s1_q   <= p1_s0_q;
            p2_s0_q   <= sa_pout2;
        end
    end

    assign sa_w1    = wrow[0 +: B_W];
    assign sa_w2    = wrow[B_W +: B_W];
    assign sa_w3    = wrow[2*B_W +: B_W];
    assign sa_act1  = act1_q;
    assign sa_act2  = act2_q;
    assign sa_act3  = act3_q;
    assign sa_psum1 = '0;
    assign sa_psum2 = '0;
    assign sa_psum3 = '0;

    // Column 3 leaves the array already aligned, so it passes straight through
    assign res_valid = vld_q[LAT-1];
    assign res_vec   = res_valid ? {relu(sa_pout3), relu(p2_s0_q), relu(p1_s1_q)} : '0;

endmodule
